// File: rtl/batpu_screen_overlay.sv
// batpu_screen_overlay: double-buffered 32x32 BatPU screen scaled and overlaid on active video.
// Buffer swaps are deferred to a vsync leading edge so the displayed bank never tears.
module batpu_screen_overlay #(
  parameter int SCALE_LOG2 = 3,
  parameter int H_OFF      = 272,
  parameter int V_OFF      = 112
) (
  input  logic        I_pxl_clk,
  input  logic        I_rst,
  input  logic        I_hs_pol,
  input  logic        I_vs_pol,
  input  logic        I_de,
  input  logic        I_hs,
  input  logic        I_vs,
  input  logic [7:0]  I_data_r,
  input  logic [7:0]  I_data_g,
  input  logic [7:0]  I_data_b,
  input  logic [23:0] I_fg_rgb,
  input  logic [23:0] I_bg_rgb,
  input  logic        I_wr_en,
  input  logic [4:0]  I_wr_x,
  input  logic [4:0]  I_wr_y,
  input  logic        I_wr_val,
  input  logic        I_clr,
  input  logic        I_push,
  output logic        O_busy,
  output logic        O_swap_pend,
  output logic        O_de,
  output logic        O_hs,
  output logic        O_vs,
  output logic [7:0]  O_data_r,
  output logic [7:0]  O_data_g,
  output logic [7:0]  O_data_b
);
  localparam logic [11:0] HB = 12'(H_OFF);
  localparam logic [11:0] HE = 12'(H_OFF + (32 << SCALE_LOG2));
  localparam logic [11:0] VB = 12'(V_OFF);
  localparam logic [11:0] VE = 12'(V_OFF + (32 << SCALE_LOG2));
  typedef enum logic {IDLE, PEND} state_t;
  state_t      state_q, state_d;
  logic [31:0] mem_q [2][32];
  logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, hpos;
  logic [4:0]  crow_q, crow_d, col1_q, row, col;
  logic [31:0] word1_q;
  logic [23:0] rgb1_q, rgb2_q, rgb_d;
  logic        busy_q, busy_d, front_q, front_d;
  logic        win1_q, de1_q, hs1_q, vs1_q, de2_q, hs2_q, vs2_q;
  logic        hs_a, vs_a, vs_edge, de_rise, de_fall, in_win, clr_go, swap;
  // Sync levels are tracked as "active" flags so reset means inactive for either polarity.
  always_comb begin
    hs_a    = I_hs == I_hs_pol;
    vs_a    = I_vs == I_vs_pol;
    vs_edge = vs_a & ~vs1_q;
    de_rise = I_de & ~de1_q;
    de_fall = ~I_de & de1_q;
    hpos    = de_rise ? 12'd0 : hcnt_q;
    hcnt_d  = I_de ? (&hpos ? hpos : hpos + 12'd1) : hcnt_q;
    vcnt_d  = vs_edge ? 12'd0 : (de_fall && !(&vcnt_q)) ? vcnt_q + 12'd1 : vcnt_q;
    in_win  = I_de && hpos >= HB && hpos < HE && vcnt_q >= VB && vcnt_q < VE;
    col     = 5'((hpos - HB) >> SCALE_LOG2);
    row     = 5'd31 - 5'((vcnt_q - VB) >> SCALE_LOG2);
    clr_go  = I_clr & ~busy_q;
    busy_d  = clr_go | (busy_q & ~(&crow_q));
    crow_d  = busy_q ? crow_q + 5'd1 : 5'd0;
    swap    = state_q == PEND && vs_edge && !busy_q;
    state_d = state_q == IDLE ? (I_push ? PEND : IDLE) : (swap ? IDLE : PEND);
    front_d = front_q ^ swap;
    rgb_d   = win1_q ? (word1_q[col1_q] ? I_fg_rgb : I_bg_rgb) : rgb1_q;
  end
  always_ff @(posedge I_pxl_clk or posedge I_rst)
    if (I_rst) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 32; j++)
          mem_q[i][j] <= '0;
    end else if (busy_q) begin
      mem_q[~front_q][crow_q] <= '0;
    end else if (I_wr_en && !I_clr) begin
      mem_q[~front_q][I_wr_y][I_wr_x] <= I_wr_val;
    end
  always_ff @(posedge I_pxl_clk or posedge I_rst)
    if (I_rst) begin
      state_q <= IDLE;
      front_q <= 1'b0;
      busy_q  <= 1'b0;
      crow_q  <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      word1_q <= '0;
      col1_q  <= '0;
      win1_q  <= 1'b0;
      rgb1_q  <= '0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      rgb2_q  <= '0;
      de2_q   <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      busy_q  <= busy_d;
      crow_q  <= crow_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      word1_q <= mem_q[front_q][row];
      col1_q  <= col;
      win1_q  <= in_win;
      rgb1_q  <= {I_data_b, I_data_g, I_data_r};
      de1_q   <= I_de;
      hs1_q   <= hs_a;
      vs1_q   <= vs_a;
      rgb2_q  <= rgb_d;
      de2_q   <= de1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
    end
  assign O_busy      = busy_q;
  assign O_swap_pend = state_q == PEND;
  assign O_de        = de2_q;
  assign O_hs        = hs2_q ~^ I_hs_pol;
  assign O_vs        = vs2_q ~^ I_vs_pol;
  assign O_data_r    = rgb2_q[7:0];
  assign O_data_g    = rgb2_q[15:8];
  assign O_data_b    = rgb2_q[23:16];
endmodule

// File: tb/tb_batpu_screen_overlay.sv
// tb_batpu_screen_overlay: control-table vectors plus small-frame video checked against a bank/pixel model.
module tb_batpu_screen_overlay;
  localparam int S = 1, HO = 6, VO = 4, SC = 2, WIN = 32 * SC;
  localparam int HACT = 72, HTOT = 80, VACT = 70, VTOT = 74;
  logic clk = 0, rst = 1, hpol = 1, vpol = 1, de = 0, hs = 0, vs = 0;
  logic [7:0] r = 0, g = 0, b = 0;
  logic [23:0] fg = 0, bg = 0;
  logic wr_en = 0, wr_val = 0, clr = 0, push = 0;
  logic [4:0] wr_x = 0, wr_y = 0;
  logic busy, pend, ode, ohs, ovs;
  logic [7:0] o_r, o_g, o_b;
  int total = 0, bad = 0, err_cnt = 0, px = 0, ln = 0, clr_left = 0;
  bit nocheck = 0, front = 0, pend_m = 0, vs_last = 0;
  string first_msg;
  bit [31:0] bank [2][32];
  typedef struct {logic de, hs, vs; logic [23:0] rgb;} exp_t;
  typedef struct packed {logic clr, wr, push, vs; logic [5:0] n; logic eb, ep;} vec_t;
  exp_t e_prev;
  vec_t tbl [20];

  always #5 clk = ~clk;

  batpu_screen_overlay #(.SCALE_LOG2(S), .H_OFF(HO), .V_OFF(VO)) dut (
    .I_pxl_clk(clk), .I_rst(rst), .I_hs_pol(hpol), .I_vs_pol(vpol),
    .I_de(de), .I_hs(hs), .I_vs(vs),
    .I_data_r(r), .I_data_g(g), .I_data_b(b),
    .I_fg_rgb(fg), .I_bg_rgb(bg),
    .I_wr_en(wr_en), .I_wr_x(wr_x), .I_wr_y(wr_y), .I_wr_val(wr_val),
    .I_clr(clr), .I_push(push),
    .O_busy(busy), .O_swap_pend(pend), .O_de(ode), .O_hs(ohs), .O_vs(ovs),
    .O_data_r(o_r), .O_data_g(o_g), .O_data_b(o_b)
  );

  function automatic exp_t rst_exp();
    exp_t e;
    e.de = 0; e.hs = ~hpol; e.vs = ~vpol; e.rgb = '0;
    return e;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 32; k++) begin
      bank[0][5'(k)] = '0;
      bank[1][5'(k)] = '0;
    end
    front = 0; pend_m = 0; clr_left = 0; vs_last = 0;
  endfunction

  // Pixel (px, ln) maps to a SCxSC block; display top is bitmap row 31.
  function automatic exp_t expect_now();
    exp_t e;
    e.de = de; e.hs = hs; e.vs = vs; e.rgb = {b, g, r};
    if (de && px >= HO && px < HO + WIN && ln >= VO && ln < VO + WIN)
      e.rgb = bank[front][5'(31 - (ln - VO) / SC)][5'((px - HO) / SC)] ? fg : bg;
    return e;
  endfunction

  // A clear wipes the whole back bank at once: it is invisible and write-locked until done.
  function automatic void model_edge();
    bit vedge, busy_pre;
    vedge = (vs == vpol) && !vs_last;
    busy_pre = clr_left > 0;
    vs_last = (vs == vpol);
    if (wr_en && !busy_pre && !clr) bank[~front][wr_y][wr_x] = wr_val;
    if (pend_m) begin
      if (vedge && !busy_pre) begin front = ~front; pend_m = 0; end
    end else if (push) pend_m = 1;
    if (busy_pre) clr_left--;
    else if (clr) begin
      clr_left = 32;
      for (int k = 0; k < 32; k++) bank[~front][5'(k)] = '0;
    end
  endfunction

  function automatic void note(string m);
    if (err_cnt == 0) first_msg = m;
    err_cnt++;
  endfunction

  function automatic void flush(string name);
    total++;
    if (err_cnt != 0) begin
      bad++;
      $display("FAIL %s: %0d bad cycles, first: %s", name, err_cnt, first_msg);
    end
    err_cnt = 0;
  endfunction

  function automatic void check(string name, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endfunction

  task automatic step();
    exp_t en = expect_now();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (!nocheck && {ode, ohs, ovs, o_b, o_g, o_r} !== {e_prev.de, e_prev.hs, e_prev.vs, e_prev.rgb})
      note($sformatf("t=%0t px=%0d ln=%0d got %b%b%b/%h want %b%b%b/%h", $time, px, ln,
                     ode, ohs, ovs, {o_b, o_g, o_r}, e_prev.de, e_prev.hs, e_prev.vs, e_prev.rgb));
    if ({busy, pend} !== {clr_left > 0, pend_m})
      note($sformatf("t=%0t busy/pend got %b%b want %b%b", $time, busy, pend, clr_left > 0, pend_m));
    e_prev = en;
  endtask

  function automatic void wr(int x, int y);
    wr_en = 1; wr_x = 5'(x); wr_y = 5'(y); wr_val = 1;
  endfunction

  task automatic mid_reset();
    check("pend_before_rst", {63'd0, pend}, 64'd1);
    #1 rst = 1;
    #1;
    check("rst_async_outputs", {ode, busy, pend, o_b, o_g, o_r}, 64'd0);
    check("rst_async_sync", {ohs, ovs}, {~hpol, ~vpol});
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    e_prev = rst_exp();
    nocheck = 1;
  endtask

  task automatic frame(input int f);
    int t;
    fg = 24'($urandom);
    bg = 24'($urandom);
    for (int l = 0; l < VTOT; l++)
      for (int c = 0; c < HTOT; c++) begin
        t = l * HTOT + c;
        de = l < VACT && c < HACT; px = c; ln = l;
        hs = (c >= 74 && c < 77) ? hpol : ~hpol;
        vs = (l >= VACT + 1 && l < VACT + 3) ? vpol : ~vpol;
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        wr_en = 0; clr = 0; push = 0;
        case (f)
          0: begin if (t == 100) wr(0, 0); if (t == 200) push = 1; end
          1: if (t == 100) wr(31, 31);
          2: if (t == 300) push = 1;
          3: begin
            if (t == 1000) begin clr = 1; wr(5, 5); end
            if (t > 1000 && t <= 1031) wr(t - 1000, 3);
            if (t == 1010) push = 1;
          end
          4: begin
            if (t == (VACT + 1) * HTOT - 10) clr = 1;
            if (t == (VACT + 1) * HTOT - 5) push = 1;
          end
          5: if (t == 100) wr(10, 20);
          6, 7: begin
            wr_en = $urandom_range(3) == 0;
            wr_x = 5'($urandom); wr_y = 5'($urandom); wr_val = 1'($urandom);
            clr = $urandom_range(2999) == 0;
            push = $urandom_range(1999) == 0 || (f == 7 && t == 100);
          end
          8: if (t == 50) push = 1;
          default: ;
        endcase
        step();
        if (f == 8 && t == 30 * HTOT + 75) mid_reset();
      end
    flush($sformatf("frame%0d", f));
    nocheck = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = {4'b0010, 6'd1,  2'b01};
    tbl[1]  = {4'b0000, 6'd3,  2'b01};
    tbl[2]  = {4'b0001, 6'd1,  2'b00};
    tbl[3]  = {4'b0001, 6'd2,  2'b00};
    tbl[4]  = {4'b0000, 6'd1,  2'b00};
    tbl[5]  = {4'b1100, 6'd1,  2'b10};
    tbl[6]  = {4'b0010, 6'd1,  2'b11};
    tbl[7]  = {4'b0001, 6'd1,  2'b11};
    tbl[8]  = {4'b0000, 6'd29, 2'b11};
    tbl[9]  = {4'b0000, 6'd1,  2'b01};
    tbl[10] = {4'b0001, 6'd1,  2'b00};
    tbl[11] = {4'b1000, 6'd1,  2'b10};
    tbl[12] = {4'b1000, 6'd5,  2'b10};
    tbl[13] = {4'b0000, 6'd26, 2'b10};
    tbl[14] = {4'b0000, 6'd1,  2'b00};
    tbl[15] = {4'b0011, 6'd1,  2'b01};
    tbl[16] = {4'b0000, 6'd3,  2'b01};
    tbl[17] = {4'b0011, 6'd1,  2'b00};
    tbl[18] = {4'b0000, 6'd1,  2'b00};
    tbl[19] = {4'b1011, 6'd1,  2'b11};
    model_reset();
    e_prev = rst_exp();
    #1;
    check("rst_out_pol1", {ode, ohs, ovs, busy, pend, o_b, o_g, o_r}, 64'd0);
    hpol = 0; vpol = 0;
    #1;
    check("rst_sync_pol0", {ohs, ovs}, 64'd3);
    hpol = 1; vpol = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      clr = tbl[i].clr; wr_en = tbl[i].wr; push = tbl[i].push; vs = tbl[i].vs;
      wr_x = 5'($urandom); wr_y = 5'($urandom); wr_val = 1;
      repeat (tbl[i].n) step();
      check($sformatf("tbl%0d_busy_pend", i), {busy, pend}, {tbl[i].eb, tbl[i].ep});
    end
    flush("table_model");
    rst = 1; hpol = 0; vpol = 0; hs = 1; vs = 1; clr = 0; push = 0; wr_en = 0;
    #1;
    check("rst_clears_busy_pend", {busy, pend}, 64'd0);
    @(negedge clk);
    rst = 0;
    model_reset();
    e_prev = rst_exp();
    for (int f = 0; f < 10; f++) frame(f);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/batpu_screen_overlay.md
Name: batpu_screen_overlay

Overview:
- Sits directly downstream of the video timing/test-pattern generator, in the pixel clock domain, before the TMDS/RGB output stage.
- Holds the BatPU 32x32 monochrome screen in a double buffer. The CPU side writes the back buffer; the front buffer is scaled and overlaid onto the incoming active video.
- Buffer swaps occur only at vertical sync, so the display never tears.

Parameters:
SCALE_LOG2, 3, log2 of the pixel-replication factor (3 gives each BatPU pixel as an 8x8 block, a 256x256 window)
H_OFF, 272, first active-area column of the window (in DE-counted pixels)
V_OFF, 112, first active-area line of the window

Ports:
I_pxl_clk  in  1  pixel clock; the only clock
I_rst  in  1  asynchronous, active-high reset
I_hs_pol  in  1  sync polarity, same meaning as the generator: 1 = sync pulse high
I_vs_pol  in  1  as I_hs_pol, for vertical sync
I_de  in  1  upstream data enable
I_hs  in  1  upstream horizontal sync
I_vs  in  1  upstream vertical sync
I_data_r / I_data_g / I_data_b  in  8 each  upstream pixel colour
I_fg_rgb  in  24  colour for lit pixels, {B,G,R}
I_bg_rgb  in  24  colour for unlit pixels inside the window, {B,G,R}
I_wr_en  in  1  write one back-buffer pixel
I_wr_x  in  5  write column, 0 = left
I_wr_y  in  5  write row, 0 = bottom (BatPU convention)
I_wr_val  in  1  pixel value to write
I_clr  in  1  start clearing the back buffer
I_push  in  1  request a front/back swap
O_busy  out  1  back-buffer clear in progress
O_swap_pend  out  1  swap requested but not yet applied
O_de / O_hs / O_vs  out  1 each  timing signals delayed to align with the data outputs
O_data_r / O_data_g / O_data_b  out  8 each  output pixel colour

Behaviour:
- Storage: two banks, each 32 rows x 32 bits. Register `front_sel` selects the displayed bank; the other bank is the back buffer.
- Reset (asynchronous, I_rst=1):
  - Both banks cleared to 0; front_sel=0.
  - O_busy=0, O_swap_pend=0, O_de=0.
  - O_hs=~I_hs_pol and O_vs=~I_vs_pol (inactive level).
  - All data outputs 0; position counters 0.
- Position tracking (inputs only):
  - hcnt is cleared on an I_de rising edge and increments each cycle I_de=1.
  - vcnt is cleared on the vsync leading edge (I_vs transitioning to the I_vs_pol level) and increments on each I_de falling edge.
  - Both counters are 12 bits and saturate at 4095.
- Window and addressing:
  - in_win = I_de & hcnt in [H_OFF, H_OFF+(32<<SCALE_LOG2)) & vcnt in [V_OFF, V_OFF+(32<<SCALE_LOG2)).
  - col = (hcnt-H_OFF)>>SCALE_LOG2.
  - row = 31-((vcnt-V_OFF)>>SCALE_LOG2); display-top shows bitmap row 31.
- Pipeline, fixed latency of 2 cycles:
  - Stage 1 registers the front-bank row word and col, in_win, and the input colour and timing.
  - Stage 2 selects the output: in_win ? (bit ? I_fg_rgb : I_bg_rgb) : the input colour, and registers it.
  - de/hs/vs are delayed exactly 2 cycles with unchanged polarity.
- Writes: when I_wr_en=1 and O_busy=0, back[I_wr_y][I_wr_x] <= I_wr_val on the next edge. Writes while O_busy=1 are dropped.
- Clear:
  - I_clr with O_busy=0 starts a clear: O_busy=1 and one back row is zeroed per cycle, rows 0..31. O_busy falls after the 32nd row, so the clear takes 32 cycles.
  - I_clr while busy is ignored.
  - I_clr and I_wr_en in the same cycle: clear wins and the write is dropped.
- Swap state machine, states IDLE and PEND:
  - IDLE -> PEND on I_push; O_swap_pend=1 in PEND.
  - PEND -> IDLE at the first vsync leading edge with O_busy=0; front_sel toggles on that edge.
  - A push while in PEND has no further effect.
  - If the vsync edge arrives during a clear, the swap waits for the next vsync.
  - I_push in the same cycle as a qualifying vsync edge: the push is captured into PEND; the swap happens on the following frame.
- Back-buffer targeting: after a swap, writes and clears target the new back bank. The old front bank keeps its contents; no copy is made.
- I_rst mid-clear or mid-pending aborts both the clear and the pending swap and restores the reset state.

Test Plan:
- Reset, 800x480 timing, no writes -> every pixel inside the window (hcnt 272..527, vcnt 112..367) equals I_bg_rgb; outside the window, output equals the input delayed 2 cycles; O_de equals I_de delayed 2.
- Write (x=0,y=0,val=1), push, wait one vsync -> fg appears at hcnt 272..279, vcnt 360..367 only; O_swap_pend falls on the vsync leading edge.
- Write (x=31,y=31,val=1) with no push -> display unchanged for 3 frames; after push and vsync, fg at hcnt 520..527, vcnt 112..119.
- I_clr and I_wr_en asserted together, then writes on cycles 1..31 -> O_busy high for exactly 32 cycles; no write lands; back bank all zero.
- I_push issued during a clear that spans a vsync leading edge -> front_sel unchanged on that edge; swap applied on the next vsync edge.
- Assert I_rst mid-frame with O_swap_pend=1 -> outputs go to reset values asynchronously; O_swap_pend=0; display reverts to all-bg bank 0.
